bin_to_bcd_seq: RTL

- Sequential double-dabble converter: binary word in, packed BCD digit word out.
- Sits directly upstream of the seven-segment decoder. Its bcd output drives the decoder's 32-bit data input, one nibble per digit; digit 0 is bcd[3:0].
- Adds saturation on overflow and a leading-zero blank mask so sensor readings display cleanly.
- One iteration per clock; no multipliers or dividers.

---
 rtl/bin_to_bcd_seq_if.sv | 33 +++
 rtl/bin_to_bcd_seq.sv | 125 ++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq_if.sv
// rtl/bin_to_bcd_seq_if.sv - request/result bundle for the sequential binary-to-BCD converter
interface bin_to_bcd_seq_if #(
    parameter int BIN_W  = 27,
    parameter int DIGITS = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [BIN_W-1:0]      bin;
    logic [4*DIGITS-1:0]   bcd;
    logic [DIGITS-1:0]     blank;
    logic                  overflow;
    logic                  out_valid;

    modport master (
        output in_valid,
        output bin,
        input  in_ready,
        input  bcd,
        input  blank,
        input  overflow,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  bin,
        output in_ready,
        output bcd,
        output blank,
        output overflow,
        output out_valid
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - double-dabble binary to packed BCD, one iteration per clock
// Saturates to all nines when the input exceeds DIGITS decimal digits; flags leading zeros.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 27,
    parameter int DIGITS = 8
) (
    input  logic              clk,
    input  logic              rst,
    bin_to_bcd_seq_if.slave   bus
);
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = 4 * DIGITS;

    function automatic logic [63:0] max_decimal(input int d);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < d; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

    localparam logic [63:0]       MAX_VAL   = max_decimal(DIGITS);
    localparam logic [CNT_W-1:0]  LAST_IT   = CNT_W'(BIN_W - 1);
    localparam logic [BCD_W-1:0]  SAT_BCD   = {DIGITS{4'h9}};
    localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [BIN_W-1:0]    bin_sr;
    logic [BCD_W-1:0]    acc;
    logic                ovf_pend;
    logic [BCD_W-1:0]    bcd_r;
    logic [DIGITS-1:0]   blank_r;
    logic                ovf_r;
    logic                out_valid_r;
    logic [BCD_W-1:0]    adj;
    logic [BCD_W-1:0]    final_bcd;

    // Per-digit correction; nibbles never carry into their neighbours.
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] a);
        logic [BCD_W-1:0] r;
        r = a;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = a[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Digit 0 is never blanked so a zero result still shows a single "0".
    function automatic logic [DIGITS-1:0] lead_zero(input logic [BCD_W-1:0] v);
        logic [DIGITS-1:0] m;
        logic              z;
        m = '0;
        z = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            z    = z & (v[4*i +: 4] == 4'd0);
            m[i] = z;
        end
        return m;
    endfunction

    assign adj       = add3(acc);
    assign final_bcd = ovf_pend ? SAT_BCD : acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            bin_sr      <= '0;
            acc         <= '0;
            ovf_pend    <= 1'b0;
            bcd_r       <= '0;
            blank_r     <= BLANK_RST;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        bin_sr   <= bus.bin;
                        acc      <= '0;
                        cnt      <= '0;
                        ovf_pend <= (64'(bus.bin) > MAX_VAL);
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Top accumulator bit falls off only for inputs that get saturated anyway.
                    acc    <= {adj[BCD_W-2:0], bin_sr[BIN_W-1]};
                    bin_sr <= {bin_sr[BIN_W-2:0], 1'b0};
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST_IT) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bcd_r       <= final_bcd;
                    blank_r     <= lead_zero(final_bcd);
                    ovf_r       <= ovf_pend;
                    out_valid_r <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.bcd       = bcd_r;
    assign bus.blank     = blank_r;
    assign bus.overflow  = ovf_r;
    assign bus.out_valid = out_valid_r;
endmodule
